// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AXI channel bundle between the cache memory ports and axi_mem_responder
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [3:0]            AWID;
  logic [4:0]            AWLEN;
  logic [ADDR_WIDTH-1:0] AWADDR;

  logic                  WVALID;
  logic                  WREADY;
  logic [3:0]            WID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;

  logic                  BVALID;
  logic                  BREADY;
  logic [3:0]            BID;
  logic [1:0]            BRESP;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [3:0]            ARID;
  logic [4:0]            ARLEN;
  logic [ADDR_WIDTH-1:0] ARADDR;

  logic                  RVALID;
  logic                  RREADY;
  logic [3:0]            RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RLAST;

  modport master (
    output AWVALID, AWID, AWLEN, AWADDR, input AWREADY,
    output WVALID, WID, WDATA, WLAST, input WREADY,
    input BVALID, BID, BRESP, output BREADY,
    output ARVALID, ARID, ARLEN, ARADDR, input ARREADY,
    input RVALID, RID, RDATA, RLAST, output RREADY
  );

  modport slave (
    input AWVALID, AWID, AWLEN, AWADDR, output AWREADY,
    input WVALID, WID, WDATA, WLAST, output WREADY,
    output BVALID, BID, BRESP, input BREADY,
    input ARVALID, ARID, ARLEN, ARADDR, output ARREADY,
    output RVALID, RID, RDATA, RLAST, input RREADY
  );
endinterface

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - single-transaction AXI memory responder for the cache ports
// Optional WLAST/WID checking with protocol_err and SLVERR is enabled by AXI_MEM_LAST_CHECK_EN.
module axi_mem_responder #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 65536,
  parameter int READ_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_mem_responder_if.slave     bus,
  output logic                   protocol_err
);

  localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WAIT_LAST = (READ_LATENCY > 2) ? READ_LATENCY - 2 : 0;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_BURST} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx, idx_inc;
  logic [3:0]            id;
  logic [4:0]            len, cnt;
  logic [7:0]            lat_cnt;
  logic                  burst_err;
  logic                  aw_hs, ar_hs, w_hs, r_hs, last_beat;
  logic                  unused_ok;

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] word;
    word = 32'(addr[ADDR_WIDTH-1:2]);
    return IDX_W'(word % 32'(DEPTH_WORDS));
  endfunction

  // A LEN of zero still moves one beat.
  function automatic logic [4:0] beat_count(input logic [4:0] l);
    return (l == 5'd0) ? 5'd1 : l;
  endfunction

  assign idx_inc   = (idx == IDX_W'(DEPTH_WORDS - 1)) ? '0 : idx + IDX_W'(1);
  assign last_beat = (cnt == len - 5'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    aw_hs       = 1'b0;
    ar_hs       = 1'b0;
    w_hs        = 1'b0;
    r_hs        = 1'b0;
    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.BID     = '0;
    bus.BRESP   = 2'b00;
    bus.RVALID  = 1'b0;
    bus.RID     = '0;
    bus.RDATA   = '0;
    bus.RLAST   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          bus.AWREADY = 1'b1;
          // Write wins a same-cycle tie so a dirty flush lands before its refill.
          bus.ARREADY = !bus.AWVALID;
          if (bus.AWVALID) begin
            aw_hs      = 1'b1;
            state_next = WR_DATA;
          end else if (bus.ARVALID) begin
            ar_hs      = 1'b1;
            state_next = (READ_LATENCY > 1) ? RD_WAIT : RD_BURST;
          end
        end
      end
      WR_DATA: begin
        bus.WREADY = !rst;
        if (bus.WVALID && !rst) begin
          w_hs = 1'b1;
          if (last_beat) state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        bus.BVALID = 1'b1;
        bus.BID    = id;
        bus.BRESP  = burst_err ? 2'b10 : 2'b00;
        if (bus.BREADY) state_next = IDLE;
      end
      RD_WAIT: begin
        if (lat_cnt == 8'(WAIT_LAST)) state_next = RD_BURST;
      end
      RD_BURST: begin
        bus.RVALID = 1'b1;
        bus.RID    = id;
        bus.RDATA  = mem[idx];
        bus.RLAST  = last_beat;
        if (bus.RREADY) begin
          r_hs = 1'b1;
          if (last_beat) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef AXI_MEM_LAST_CHECK_EN
  logic perr_q;
  assign protocol_err = perr_q;
  assign unused_ok    = ^{bus.AWADDR[1:0], bus.ARADDR[1:0]};
`else
  assign protocol_err = 1'b0;
  assign unused_ok    = ^{bus.AWADDR[1:0], bus.ARADDR[1:0], bus.WLAST, bus.WID};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      id        <= '0;
      len       <= '0;
      cnt       <= '0;
      lat_cnt   <= '0;
      burst_err <= 1'b0;
`ifdef AXI_MEM_LAST_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      if (aw_hs) begin
        idx       <= word_index(bus.AWADDR);
        id        <= bus.AWID;
        len       <= beat_count(bus.AWLEN);
        cnt       <= '0;
        burst_err <= 1'b0;
      end else if (ar_hs) begin
        idx     <= word_index(bus.ARADDR);
        id      <= bus.ARID;
        len     <= beat_count(bus.ARLEN);
        cnt     <= '0;
        lat_cnt <= '0;
      end
      if (w_hs || r_hs) begin
        idx <= idx_inc;
        cnt <= cnt + 5'd1;
      end
      if (state == RD_WAIT) lat_cnt <= lat_cnt + 8'd1;
`ifdef AXI_MEM_LAST_CHECK_EN
      // The beat is still stored; only the response and the sticky flag record the fault.
      if (w_hs && ((bus.WLAST != last_beat) || (bus.WID != id))) begin
        burst_err <= 1'b1;
        perr_q    <= 1'b1;
`ifndef SYNTHESIS
        $error("axi_mem_responder: bad WLAST/WID at word %0d beat %0d", idx, cnt);
`endif
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) mem[idx] <= bus.WDATA;
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - randomized self-checking bench for axi_mem_responder
module tb_axi_mem_responder;
  localparam int AW    = 26;
  localparam int DW    = 32;
  localparam int DEPTH = 65536;
  localparam int RL    = 4;

  logic clk = 1'b0;
  logic rst;
  logic protocol_err;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .protocol_err(protocol_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
    bus.WVALID  = 0; bus.WID  = 0; bus.WDATA = 0; bus.WLAST  = 0;
    bus.BREADY  = 0;
    bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0; bus.ARADDR = 0;
    bus.RREADY  = 0;
  endtask

  // stop_at >= 0: reset is pulsed after that many beats and no response is expected.
  task automatic do_write(input logic [AW-1:0] addr, input logic [4:0] len, input logic [3:0] id,
                          input int bad_last, input logic [1:0] exp_resp, input bit gaps,
                          input int stop_at);
    int beats_n, n, w0;
    logic [31:0] d;
    beats_n = (len == 0) ? 1 : int'(len);
    w0 = int'(addr[AW-1:2]) % DEPTH;
    bus.AWVALID = 1; bus.AWADDR = addr; bus.AWLEN = len; bus.AWID = id;
    #1;
    n = 0;
    while (!bus.AWREADY && n < 100) begin step(); #1; n++; end
    check_eq("aw_ready", bus.AWREADY, 1);
    step();
    bus.AWVALID = 0;
    for (int i = 0; i < beats_n; i++) begin
      if (i == stop_at) begin
        rst = 1; step(); rst = 0; #1;
        check_eq("wr_abort_bvalid", bus.BVALID, 0);
        check_eq("wr_abort_wready", bus.WREADY, 0);
        check_eq("wr_abort_awready", bus.AWREADY, 1);
        return;
      end
      if (gaps) repeat ($urandom_range(0, 2)) step();
      d = $urandom;
      bus.WVALID = 1; bus.WDATA = d; bus.WID = id;
      bus.WLAST = (i == beats_n - 1) || (i == bad_last);
      #1;
      n = 0;
      while (!bus.WREADY && n < 100) begin step(); #1; n++; end
      check_eq("w_ready", bus.WREADY, 1);
      step();
      bus.WVALID = 0; bus.WLAST = 0;
      model[(w0 + i) % DEPTH] = d;
    end
    #1;
    check_eq("b_valid", bus.BVALID, 1);
    check_eq("b_id", bus.BID, id);
    check_eq("b_resp", bus.BRESP, exp_resp);
    check_eq("w_ready_after", bus.WREADY, 0);
    repeat ($urandom_range(0, 2)) begin
      step(); #1;
      check_eq("b_hold", bus.BVALID, 1);
    end
    bus.BREADY = 1;
    step();
    bus.BREADY = 0;
    #1;
    check_eq("b_done", bus.BVALID, 0);
  endtask

  // mode 0: RREADY always high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic do_read(input logic [AW-1:0] addr, input logic [4:0] len, input logic [3:0] id,
                         input int mode);
    int beats_n, n, w0, cyc, beat, k;
    bit rr;
    beats_n = (len == 0) ? 1 : int'(len);
    w0 = int'(addr[AW-1:2]) % DEPTH;
    bus.ARVALID = 1; bus.ARADDR = addr; bus.ARLEN = len; bus.ARID = id;
    #1;
    n = 0;
    while (!bus.ARREADY && n < 100) begin step(); #1; n++; end
    check_eq("ar_ready", bus.ARREADY, 1);
    step();
    bus.ARVALID = 0;
    cyc = 1;
    #1;
    while (!bus.RVALID && cyc < 50) begin step(); #1; cyc++; end
    check_eq("r_latency", cyc, RL);
    beat = 0; k = 0;
    while (beat < beats_n && k < 200) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
      check_eq("r_valid", bus.RVALID, 1);
      check_eq("r_data", bus.RDATA, model[(w0 + beat) % DEPTH]);
      check_eq("r_id", bus.RID, id);
      check_eq("r_last", bus.RLAST, beat == beats_n - 1);
      bus.RREADY = rr;
      step();
      bus.RREADY = 0;
      #1;
      if (rr) beat++;
    end
    check_eq("r_beats", beat, beats_n);
    check_eq("r_end", bus.RVALID, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic exp_perr;
    exp_perr = 0;
    idle_bus();
    rst = 1;
    repeat (3) step();
    #1;
    check_eq("rst_awready", bus.AWREADY, 0);
    check_eq("rst_arready", bus.ARREADY, 0);
    check_eq("rst_wready", bus.WREADY, 0);
    check_eq("rst_bvalid", bus.BVALID, 0);
    check_eq("rst_rvalid", bus.RVALID, 0);
    check_eq("rst_rlast", bus.RLAST, 0);
    check_eq("rst_ids", {bus.BID, bus.RID}, 0);
    check_eq("rst_bresp", bus.BRESP, 0);
    check_eq("rst_rdata", bus.RDATA, 0);
    check_eq("rst_perr", protocol_err, 0);
    rst = 0;
    #1;
    check_eq("idle_awready", bus.AWREADY, 1);
    check_eq("idle_arready", bus.ARREADY, 1);

    do_write(26'h100, 5'd4, 4'd5, -1, 2'b00, 0, -1);
    do_read(26'h100, 5'd4, 4'd6, 0);
    do_read(26'h100, 5'd4, 4'd7, 1);

    // Simultaneous AW and AR to the same line.
    bus.ARVALID = 1; bus.ARADDR = 26'h140; bus.ARLEN = 5'd2; bus.ARID = 4'd9;
    bus.AWVALID = 1; bus.AWADDR = 26'h140; bus.AWLEN = 5'd2; bus.AWID = 4'd3;
    #1;
    check_eq("tie_awready", bus.AWREADY, 1);
    check_eq("tie_arready", bus.ARREADY, 0);
    do_write(26'h140, 5'd2, 4'd3, -1, 2'b00, 0, -1);
    do_read(26'h140, 5'd2, 4'd9, 0);

    // Burst across the top of memory wraps to word 0.
    do_write(AW'((DEPTH - 2) * 4), 5'd4, 4'd1, -1, 2'b00, 1, -1);
    do_read(AW'((DEPTH - 2) * 4 + 3), 5'd4, 4'd2, 2);
    do_read(26'h0, 5'd2, 4'd2, 0);

    // Reset during beat 2 of a read.
    bus.ARVALID = 1; bus.ARADDR = 26'h100; bus.ARLEN = 5'd4; bus.ARID = 4'd4;
    step();
    bus.ARVALID = 0;
    #1;
    n = 0;
    while (!bus.RVALID && n < 50) begin step(); #1; n++; end
    check_eq("abort_rvalid_b1", bus.RVALID, 1);
    bus.RREADY = 1; step(); bus.RREADY = 0; #1;
    check_eq("abort_rdata_b2", bus.RDATA, model[(16'h100 >> 2) + 1]);
    rst = 1; step(); rst = 0; #1;
    check_eq("abort_rvalid", bus.RVALID, 0);
    check_eq("abort_arready", bus.ARREADY, 1);
    check_eq("abort_rdata", bus.RDATA, 0);
    do_read(26'h100, 5'd4, 4'd8, 0);

    // Reset after two beats of a write: those beats persist.
    do_write(26'h180, 5'd4, 4'd2, -1, 2'b00, 0, 2);
    do_read(26'h180, 5'd2, 4'd2, 0);

`ifdef AXI_MEM_LAST_CHECK_EN
    do_write(26'h200, 5'd4, 4'd3, 1, 2'b10, 0, -1);
    check_eq("perr_set", protocol_err, 1);
    exp_perr = 1;
`endif

    // Fill words 0..127, then random traffic within that region.
    for (int b = 0; b < 8; b++) do_write(AW'(b * 64), 5'd16, 4'(b), -1, 2'b00, 0, -1);
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic [4:0] l;
      a = AW'($urandom_range(0, 111) * 4 + $urandom_range(0, 3));
      l = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, 4'($urandom), -1, 2'b00, 1, -1);
      else
        do_read(a, l, 4'($urandom), 2);
    end
    check_eq("perr_final", protocol_err, exp_perr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
